// File: rtl/veririscv_mem_arbiter_pkg.sv
// Shared types and defaults for the unified-RAM arbiter between instruction fetch and the MEM stage.
package veririscv_mem_arbiter_pkg;

  localparam int ADDR_W_DEFAULT     = 16;
  localparam int DATA_W_DEFAULT     = 32;
  localparam int STARVE_MAX_DEFAULT = 3;
  localparam int STARVE_CNT_W       = 4;

  // Who owns the read response that the RAM returns in the current cycle.
  typedef enum logic [1:0] {
    RD_OWNER_NONE = 2'd0,
    RD_OWNER_IBUS = 2'd1,
    RD_OWNER_DBUS = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/veririscv_mem_arbiter.sv
// Single-port RAM arbiter: dbus has priority, ibus is forced through after STARVE_MAX losses;
// read responses are steered back to the requester that issued them.
module veririscv_mem_arbiter
  import veririscv_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEFAULT,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ibus_req,
  input  logic [ADDR_W-1:0]   ibus_addr,
  output logic                ibus_gnt,
  output logic                ibus_rvalid,
  output logic [DATA_W-1:0]   ibus_rdata,
  input  logic                dbus_req,
  input  logic                dbus_we,
  input  logic [DATA_W/8-1:0] dbus_be,
  input  logic [ADDR_W-1:0]   dbus_addr,
  input  logic [DATA_W-1:0]   dbus_wdata,
  output logic                dbus_gnt,
  output logic                dbus_rvalid,
  output logic [DATA_W-1:0]   dbus_rdata,
  output logic                ram_en,
  output logic                ram_we,
  output logic [DATA_W/8-1:0] ram_be,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);

  // Handshake: a requester raises req with a stable address and holds both until it sees gnt
  // in the same cycle; gnt is combinational and nothing is buffered. A granted read returns
  // exactly one cycle later with rvalid, and rdata is only meaningful while rvalid is high.

  logic [STARVE_CNT_W-1:0] starve_cnt;
  rd_owner_e               rd_owner;
  logic                    ibus_win;
  logic                    dbus_win;

  always_comb begin
    ibus_win = 1'b0;
    dbus_win = 1'b0;
    if (!rst) begin
      ibus_win = ibus_req && (!dbus_req || (starve_cnt == STARVE_LIM));
      dbus_win = dbus_req && !ibus_win;
    end
  end

  assign ibus_gnt = ibus_win;
  assign dbus_gnt = dbus_win;
  assign ram_en   = ibus_win | dbus_win;

  // Write-side fields are held at zero unless the data port owns the RAM this cycle.
  always_comb begin
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (ibus_win) begin
      ram_addr = ibus_addr;
    end else if (dbus_win) begin
      ram_we    = dbus_we;
      ram_be    = dbus_be;
      ram_addr  = dbus_addr;
      ram_wdata = dbus_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      rd_owner   <= RD_OWNER_NONE;
    end else begin
      if (ibus_win) begin
        rd_owner <= RD_OWNER_IBUS;
      end else if (dbus_win && !dbus_we) begin
        rd_owner <= RD_OWNER_DBUS;
      end else begin
        rd_owner <= RD_OWNER_NONE;
      end

      if (ibus_win || !ibus_req) begin
        starve_cnt <= '0;
      end else if (dbus_win && (starve_cnt != STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // A read granted just before reset must not surface while reset is asserted.
  assign ibus_rvalid = !rst && (rd_owner == RD_OWNER_IBUS);
  assign dbus_rvalid = !rst && (rd_owner == RD_OWNER_DBUS);
  assign ibus_rdata  = ram_rdata;
  assign dbus_rdata  = ram_rdata;

  logic unused_be_w;
  assign unused_be_w = (BE_W == 0);

endmodule
